// File: rtl/ads_frame_packer.sv
// ads_frame_packer: turns one 32-channel ADS1278 sample frame into a framed byte stream (header, counter, trigger, data).
// The trailing checksum byte is only present when ADS_FRAME_PACKER_CHECKSUM_EN is defined.
module ads_frame_packer #(
  parameter int         NUM_CH = 32,
  parameter logic [7:0] HDR0   = 8'hAA,
  parameter logic [7:0] HDR1   = 8'h55
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 i_enable,
  input  logic                 i_clear,
  input  logic                 i_frame_valid,
  input  logic [NUM_CH*24-1:0] i_frame_data,
  input  logic [7:0]           i_tri_data,
  output logic [7:0]           o_byte,
  output logic                 o_byte_valid,
  input  logic                 i_byte_ready,
  output logic                 o_busy,
  output logic [7:0]           o_drop_cnt
);

  localparam int         NBYTES   = NUM_CH * 3;
  localparam logic [6:0] LAST_IDX = 7'(NBYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR0, ST_HDR1, ST_CNT_H, ST_CNT_L, ST_TRIG, ST_DATA
`ifdef ADS_FRAME_PACKER_CHECKSUM_EN
    , ST_CSUM
`endif
  } state_t;

  typedef struct packed {
    logic [NUM_CH*24-1:0] data;
    logic [7:0]           trig;
    logic [15:0]          cnt;
  } frame_t;

`ifdef ADS_FRAME_PACKER_CHECKSUM_EN
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction
`endif

  state_t      state_r, state_nxt_s;
  logic [6:0]  idx_r, idx_nxt_s;
  frame_t      act_r, act_nxt_s, shd_r, shd_nxt_s, new_frame_s;
  logic        shd_full_r, shd_full_nxt_s;
  logic [15:0] frame_cnt_r, frame_cnt_nxt_s, stamp_s;
  logic [7:0]  drop_cnt_r, drop_cnt_nxt_s;
  logic        drop_inc_s;
  logic [7:0]  byte_r, byte_nxt_s, byte_sel_s;
  logic        valid_r, busy_r;
  logic        accept_s, xfer_s, restart_s, pkt_end_s;
  logic [7:0]  data_bytes_s [NBYTES];
`ifdef ADS_FRAME_PACKER_CHECKSUM_EN
  logic [7:0]  csum_r, csum_nxt_s;
`endif

  assign accept_s    = i_enable & i_frame_valid;
  assign xfer_s      = valid_r & i_byte_ready;
  assign restart_s   = shd_full_r | accept_s;
  // A clear coinciding with an accepted frame stamps that frame with 0
  assign stamp_s     = i_clear ? 16'h0000 : frame_cnt_r;
  assign new_frame_s = '{data: i_frame_data, trig: i_tri_data, cnt: stamp_s};

  // Channel k occupies bits [24k+23:24k]; bytes go out MSB first, channel 0 first
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_bytes
    assign data_bytes_s[3*ch]   = act_nxt_s.data[24*ch+16 +: 8];
    assign data_bytes_s[3*ch+1] = act_nxt_s.data[24*ch+8  +: 8];
    assign data_bytes_s[3*ch+2] = act_nxt_s.data[24*ch    +: 8];
  end

  // Packet sequencing: advances only on a byte transfer
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    pkt_end_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_HDR0;
        else          state_nxt_s = ST_IDLE;
      end
      ST_HDR0: begin
        if (xfer_s) state_nxt_s = ST_HDR1;
        else        state_nxt_s = ST_HDR0;
      end
      ST_HDR1: begin
        if (xfer_s) state_nxt_s = ST_CNT_H;
        else        state_nxt_s = ST_HDR1;
      end
      ST_CNT_H: begin
        if (xfer_s) state_nxt_s = ST_CNT_L;
        else        state_nxt_s = ST_CNT_H;
      end
      ST_CNT_L: begin
        if (xfer_s) state_nxt_s = ST_TRIG;
        else        state_nxt_s = ST_CNT_L;
      end
      ST_TRIG: begin
        if (xfer_s) state_nxt_s = ST_DATA;
        else        state_nxt_s = ST_TRIG;
      end
      ST_DATA: begin
        if (xfer_s && (idx_r == LAST_IDX)) begin
          idx_nxt_s   = 7'd0;
`ifdef ADS_FRAME_PACKER_CHECKSUM_EN
          state_nxt_s = ST_CSUM;
`else
          pkt_end_s   = 1'b1;
          state_nxt_s = restart_s ? ST_HDR0 : ST_IDLE;
`endif
        end else if (xfer_s) begin
          idx_nxt_s = idx_r + 7'd1;
        end else begin
          idx_nxt_s = idx_r;
        end
      end
`ifdef ADS_FRAME_PACKER_CHECKSUM_EN
      ST_CSUM: begin
        if (xfer_s) begin
          pkt_end_s   = 1'b1;
          state_nxt_s = restart_s ? ST_HDR0 : ST_IDLE;
        end else begin
          state_nxt_s = ST_CSUM;
        end
      end
`endif
      default: begin
        state_nxt_s = ST_IDLE;
        idx_nxt_s   = 7'd0;
      end
    endcase
  end

  // Active/shadow frame storage and drop detection
  always_comb begin
    act_nxt_s      = act_r;
    shd_nxt_s      = shd_r;
    shd_full_nxt_s = shd_full_r;
    drop_inc_s     = 1'b0;
    if (state_r == ST_IDLE) begin
      if (accept_s) act_nxt_s = new_frame_s;
      else          act_nxt_s = act_r;
    end else if (pkt_end_s) begin
      if (shd_full_r) begin
        act_nxt_s = shd_r;
        if (accept_s) shd_nxt_s      = new_frame_s;
        else          shd_full_nxt_s = 1'b0;
      end else if (accept_s) begin
        act_nxt_s = new_frame_s;
      end else begin
        act_nxt_s = act_r;
      end
    end else if (accept_s) begin
      if (shd_full_r) begin
        drop_inc_s = 1'b1;
      end else begin
        shd_nxt_s      = new_frame_s;
        shd_full_nxt_s = 1'b1;
      end
    end else begin
      drop_inc_s = 1'b0;
    end
  end

  // Frame counter (dropped frames also consume a number) and saturating drop counter
  always_comb begin
    if (accept_s)     frame_cnt_nxt_s = stamp_s + 16'd1;
    else if (i_clear) frame_cnt_nxt_s = 16'd0;
    else              frame_cnt_nxt_s = frame_cnt_r;
    if (i_clear)                                      drop_cnt_nxt_s = 8'd0;
    else if (drop_inc_s && (drop_cnt_r != 8'hFF))     drop_cnt_nxt_s = drop_cnt_r + 8'd1;
    else                                              drop_cnt_nxt_s = drop_cnt_r;
  end

`ifdef ADS_FRAME_PACKER_CHECKSUM_EN
  // Running checksum over counter, trigger and data bytes; header bytes restart it
  always_comb begin
    case (state_r)
      ST_HDR0, ST_HDR1:                     csum_nxt_s = 8'h00;
      ST_CNT_H, ST_CNT_L, ST_TRIG, ST_DATA: csum_nxt_s = xfer_s ? csum_add(csum_r, byte_r) : csum_r;
      default:                              csum_nxt_s = csum_r;
    endcase
  end
`endif

  // Byte for the upcoming state; held steady until the current byte is taken
  always_comb begin
    case (state_nxt_s)
      ST_HDR0:  byte_sel_s = HDR0;
      ST_HDR1:  byte_sel_s = HDR1;
      ST_CNT_H: byte_sel_s = act_nxt_s.cnt[15:8];
      ST_CNT_L: byte_sel_s = act_nxt_s.cnt[7:0];
      ST_TRIG:  byte_sel_s = act_nxt_s.trig;
      ST_DATA:  byte_sel_s = data_bytes_s[idx_nxt_s];
`ifdef ADS_FRAME_PACKER_CHECKSUM_EN
      ST_CSUM:  byte_sel_s = csum_nxt_s;
`endif
      default:  byte_sel_s = 8'h00;
    endcase
    if ((state_r == ST_IDLE) || xfer_s) byte_nxt_s = byte_sel_s;
    else                                byte_nxt_s = byte_r;
  end

  // State, storage and registered outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r     <= ST_IDLE;
      idx_r       <= 7'd0;
      act_r       <= '0;
      shd_r       <= '0;
      shd_full_r  <= 1'b0;
      frame_cnt_r <= 16'd0;
      drop_cnt_r  <= 8'd0;
      byte_r      <= 8'd0;
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
`ifdef ADS_FRAME_PACKER_CHECKSUM_EN
      csum_r      <= 8'd0;
`endif
    end else begin
      state_r     <= state_nxt_s;
      idx_r       <= idx_nxt_s;
      act_r       <= act_nxt_s;
      shd_r       <= shd_nxt_s;
      shd_full_r  <= shd_full_nxt_s;
      frame_cnt_r <= frame_cnt_nxt_s;
      drop_cnt_r  <= drop_cnt_nxt_s;
      byte_r      <= byte_nxt_s;
      valid_r     <= (state_nxt_s != ST_IDLE);
      busy_r      <= (state_nxt_s != ST_IDLE) | shd_full_nxt_s;
`ifdef ADS_FRAME_PACKER_CHECKSUM_EN
      csum_r      <= csum_nxt_s;
`endif
    end
  end

  assign o_byte       = byte_r;
  assign o_byte_valid = valid_r;
  assign o_busy       = busy_r;
  assign o_drop_cnt   = drop_cnt_r;

endmodule
